// File: rtl/console_tx.sv
// console_tx: memory-mapped serial console transmitter.
//
// Sits on the CPU data bus beside the RAM. CPU byte writes to the register
// window BASE..BASE+3 are decoded here, bytes written to DATA are buffered
// in a 4-entry FIFO and serialised as 8N1 frames on txd (LSB first, one
// start bit, one stop bit, DIVISOR clocks per bit).
//
// Register map (offset from BASE):
//   0 DATA   write: push byte        read: 0
//   1 STATUS read : {overflow, 2'b0, count[2:0], tx_idle, tx_ready}
//            write: any value clears the sticky overflow flag
//   2 CTRL   bit0 irq_enable (only with CONSOLE_IRQ_EN), otherwise reads 0
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clock   system clock, rising edge
//   reset_n asynchronous active-low reset
//   wen/waddr/wdata  CPU write strobe, address, data
//   ren/raddr        CPU read strobe, address
//   rdata   registered read data, 0 when not selected (OR-able with RAM)
//   txd     registered serial output, idle high
//   irq     (CONSOLE_IRQ_EN only) registered irq_enable & tx_ready
//
// Optional feature macro: CONSOLE_IRQ_EN adds the irq port and CTRL register.

module console_tx #(
    parameter logic [15:0] BASE    = 16'hFF00,
    parameter int unsigned DIVISOR = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wen,
    input  logic        ren,
    input  logic [15:0] waddr,
    input  logic [15:0] raddr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        txd
`ifdef CONSOLE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] baud_r, baud_s;
    logic [2:0]  bit_r, bit_s;
    logic [7:0]  shift_r, shift_s;
    logic        txd_r, txd_s;
    logic        pop_s;

    logic [7:0]  fifo_mem_r [0:3];
    logic [1:0]  wptr_r, rptr_r;
    logic [2:0]  count_r;
    logic        ovf_r;
    logic [7:0]  rdata_r, rd_val_s;
    logic [7:0]  ctrl_val_s;

    // Address decode: window is 4-aligned so the upper 14 bits select it.
    logic wsel_s, rsel_s, push_req_s, push_ok_s, full_s, empty_s;
    logic stat_wr_s, tx_idle_s;
    logic [7:0] status_s;

    assign wsel_s     = (waddr[15:2] == BASE[15:2]);
    assign rsel_s     = (raddr[15:2] == BASE[15:2]);
    assign full_s     = (count_r == 3'd4);
    assign empty_s    = (count_r == 3'd0);
    assign push_req_s = wen & wsel_s & (waddr[1:0] == 2'd0);
    // Push acceptance looks at the count before any same-edge pop.
    assign push_ok_s  = push_req_s & ~full_s;
    assign stat_wr_s  = wen & wsel_s & (waddr[1:0] == 2'd1);
    assign tx_idle_s  = empty_s & (state_r == ST_IDLE);
    assign status_s   = {ovf_r, 2'b00, count_r, tx_idle_s, ~full_s};

`ifdef CONSOLE_IRQ_EN
    logic irq_en_r, irq_r;

    // CTRL register and registered interrupt output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (wen && wsel_s && (waddr[1:0] == 2'd2)) begin
                irq_en_r <= wdata[0];
            end
            irq_r <= irq_en_r & ~full_s;
        end
    end

    assign irq        = irq_r;
    assign ctrl_val_s = {7'b0000000, irq_en_r};
`else
    assign ctrl_val_s = 8'h00;
`endif

    // Read mux: value presented to the read data register this cycle.
    always_comb begin
        rd_val_s = 8'h00;
        if (rsel_s) begin
            case (raddr[1:0])
                2'd1:    rd_val_s = status_s;
                2'd2:    rd_val_s = ctrl_val_s;
                default: rd_val_s = 8'h00;
            endcase
        end else begin
            rd_val_s = 8'h00;
        end
    end

    // Read data register: loads on a read strobe, zero otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= 8'h00;
        end else if (ren) begin
            rdata_r <= rd_val_s;
        end else begin
            rdata_r <= 8'h00;
        end
    end

    // FIFO storage, pointers, occupancy count and sticky overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            wptr_r  <= 2'd0;
            rptr_r  <= 2'd0;
            count_r <= 3'd0;
            ovf_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wptr_r] <= wdata;
                wptr_r             <= wptr_r + 2'd1;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 2'd1;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
            // A dropped byte on the same edge as a clear keeps the flag set.
            if (push_req_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (stat_wr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Transmitter state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            baud_r  <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            txd_r   <= txd_s;
        end
    end

    // Transmitter next state; txd_s is the line level for the next cycle so
    // the pin itself is a flop.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        txd_s   = txd_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_START;
                    baud_s  = BAUD_RELOAD;
                    shift_s = fifo_mem_r[rptr_r];
                    txd_s   = 1'b0;
                end else begin
                    txd_s   = 1'b1;
                end
            end
            ST_START: begin
                if (baud_r != 16'd0) begin
                    baud_s  = baud_r - 16'd1;
                end else begin
                    state_s = ST_DATA;
                    baud_s  = BAUD_RELOAD;
                    bit_s   = 3'd0;
                    txd_s   = shift_r[0];
                end
            end
            ST_DATA: begin
                if (baud_r != 16'd0) begin
                    baud_s  = baud_r - 16'd1;
                end else if (bit_r == 3'd7) begin
                    state_s = ST_STOP;
                    baud_s  = BAUD_RELOAD;
                    txd_s   = 1'b1;
                end else begin
                    baud_s  = BAUD_RELOAD;
                    bit_s   = bit_r + 3'd1;
                    shift_s = {1'b0, shift_r[7:1]};
                    txd_s   = shift_r[1];
                end
            end
            ST_STOP: begin
                if (baud_r != 16'd0) begin
                    baud_s  = baud_r - 16'd1;
                end else if (!empty_s) begin
                    // Back-to-back frame: straight into the next start bit.
                    pop_s   = 1'b1;
                    state_s = ST_START;
                    baud_s  = BAUD_RELOAD;
                    shift_s = fifo_mem_r[rptr_r];
                    txd_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                    baud_s  = 16'd0;
                    txd_s   = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = 16'd0;
                txd_s   = 1'b1;
            end
        endcase
    end

    assign rdata = rdata_r;
    assign txd   = txd_r;

endmodule

// File: doc/console_tx.md
Name: console_tx

Overview:
- Memory-mapped serial console transmitter on the CPU data bus, beside the RAM.
- Decodes CPU byte writes/reads to a small register window and buffers bytes in a 4-entry FIFO.
- Serialises buffered bytes as 8N1 async frames on `txd`.
- Read data is registered (one-cycle latency, same as RAM) and forced to zero when unselected, so the top level ORs it with RAM `rdata`.

Parameters:
- BASE, 16'hFF00, address of register 0. Window is BASE..BASE+3; BASE must be 4-aligned.
- DIVISOR, 16, clock cycles per serial bit. Legal range 2..65535.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wen  in  1  CPU write strobe, one cycle per write.
- ren  in  1  CPU read strobe, one cycle per read.
- waddr  in  16  write address.
- raddr  in  16  read address.
- wdata  in  8  write data.
- rdata  out  8  registered read data; 0 when not selected.
- txd  out  1  serial output, idle high.

Behaviour:
- Reset (async assert, sync release)
  - txd=1, rdata=0, FIFO empty, state=IDLE, overflow=0, bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame immediately (txd=1) and discards FIFO contents.
- Register map (offset = addr - BASE)
  - 0 DATA: write pushes wdata; read returns 0.
  - 1 STATUS (read): bit0 tx_ready (FIFO not full); bit1 tx_idle (FIFO empty and state IDLE); bits4:2 fifo count 0..4; bit7 overflow; other bits 0.
  - 1 STATUS (write): any value clears overflow.
  - 2 CTRL (see optional feature).
  - 3 reserved: reads 0, writes ignored.
  - Addresses outside the window: no effect; rdata=0.
- Read timing
  - rdata is updated on the edge where ren=1 with the selected value (0 if unselected).
  - rdata returns to 0 on the next edge where ren=0.
  - Status value is sampled before same-edge updates.
- FIFO
  - 4 entries, 2-bit read/write pointers wrapping 3->0, 3-bit count.
  - Push is accepted if count<4 at the edge, evaluated before any same-edge pop.
  - Write while full: byte dropped, overflow=1 (sticky).
  - Overflow set and clear on the same edge: set wins.
- TX FSM (states IDLE, START, DATA, STOP)
  - IDLE: txd=1. If count>0 at an edge, pop head into shifter, go to START, reload baud counter to DIVISOR-1.
  - A byte written at edge N therefore drives the start bit from edge N+1.
  - Each state holds for DIVISOR cycles: baud counter decrements to 0, then advances.
  - START: txd=0.
  - DATA: txd=shifter[0], LSB first; shift right each bit; 8 bits via 3-bit counter 0..7.
  - STOP: txd=1 for DIVISOR cycles.
  - At end of STOP: go to START popping the next byte if count>0 (no idle gap), else go to IDLE.
  - Frame length is exactly 10*DIVISOR cycles.
  - Push and pop on the same edge: count unchanged, both pointers advance.
- txd is a registered output (no glitches).

Optional Feature:
- Macro: CONSOLE_IRQ_EN.
- Defined:
  - Adds output port `irq` (1 bit), placed after `txd`.
  - CTRL bit0 = irq_enable: read/write, reset 0.
  - irq is registered: irq = irq_enable & tx_ready, updating one cycle after the condition changes.
  - CTRL reads return {7'b0, irq_enable}.
- Undefined:
  - No irq port.
  - CTRL reads 0; writes ignored.

Test Plan:
- DIVISOR=4: write 8'h55 to BASE at edge 10 -> txd low for cycles 11-14, then 1,0,1,0,1,0,1,0 in 4-cycle bits, then high for 4 cycles; tx_idle=1 from cycle 51.
- Five back-to-back writes 8'h01..8'h05 while idle -> first pops immediately; bytes 2-5 fill FIFO to 4; no overflow. Sixth write before any further pop -> overflow=1, count=4. Frames for 01..05 are sent contiguously with no idle gap.
- Read STATUS after overflow -> rdata=8'b1001_0000 (count=4, tx_ready=0) one cycle after ren. Write any value to STATUS -> bit7 reads 0.
- Assert reset_n=0 mid DATA bit 3 -> txd=1 immediately; after release, STATUS reads 8'h03 and no frame is emitted.
- Write to BASE+3 and to 16'h0000 -> no FIFO change, no txd activity. Read 16'h1234 -> rdata=0. Read DATA -> rdata=0.
- With CONSOLE_IRQ_EN: write CTRL=1 while idle -> irq=1 one cycle later. Fill FIFO to full -> irq=0. Write CTRL=0 -> irq stays 0.
